// File: rtl/jt10_adpcm_romarb.sv
// Round-robin arbiter sharing one ADPCM ROM port between the A and B channels.
// Define JT10_ROMARB_CACHE_EN to answer repeated addresses from the held dout without a ROM access.
module jt10_adpcm_romarb #(
  parameter int TOUT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic [23:0] a_addr,
  output logic        a_ack,
  output logic [7:0]  a_dout,
  input  logic        b_req,
  input  logic [23:0] b_addr,
  output logic        b_ack,
  output logic [7:0]  b_dout,
  output logic [23:0] rom_addr,
  output logic        rom_cs,
  input  logic        rom_ok,
  input  logic [7:0]  rom_data,
  input  logic        flush,
  input  logic        clr_err,
  output logic        err
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_nx;
  logic              gnt, gnt_nx;    // granted requester, 1 = B
  logic              last, last_nx;  // last ROM-served requester, 1 = B
  logic [TOUT_W-1:0] cnt;
  logic              start, done_ok, tout, fin;
  logic              a_hit, b_hit, a_pend, b_pend;

  assign rom_cs  = state == BUSY;
  // cnt==0 marks the first BUSY cycle, where rom_ok still belongs to the previous access
  assign done_ok = rom_cs && cnt != '0 && rom_ok;
  assign tout    = rom_cs && !done_ok && cnt == '1;
  assign fin     = done_ok | tout;
  assign a_pend  = a_req & ~a_ack & ~a_hit;
  assign b_pend  = b_req & ~b_ack & ~b_hit;

`ifdef JT10_ROMARB_CACHE_EN
  logic [23:0] a_last, b_last;
  logic        a_vld, b_vld;

  assign a_hit = a_req & a_vld & ~flush & ~a_ack & (a_addr == a_last) & ~(rom_cs & ~gnt);
  assign b_hit = b_req & b_vld & ~flush & ~b_ack & (b_addr == b_last) & ~(rom_cs &  gnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_last <= '0;
      b_last <= '0;
      a_vld  <= 1'b0;
      b_vld  <= 1'b0;
    end else begin
      if (done_ok && !gnt) a_last <= rom_addr;
      if (done_ok &&  gnt) b_last <= rom_addr;
      // a timeout rewrites dout with 00, so the held byte no longer matches last_addr
      if (flush || (tout && !gnt))  a_vld <= 1'b0;
      else if (done_ok && !gnt)     a_vld <= 1'b1;
      if (flush || (tout && gnt))   b_vld <= 1'b0;
      else if (done_ok && gnt)      b_vld <= 1'b1;
    end
  end
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign a_hit = 1'b0;
  assign b_hit = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    last_nx  = last;
    start    = 1'b0;
    case (state)
      IDLE: if (a_pend | b_pend) begin
        start    = 1'b1;
        state_nx = BUSY;
        gnt_nx   = (a_pend & b_pend) ? ~last : b_pend;
      end
      BUSY: if (fin) begin
        state_nx = IDLE;
        if (done_ok) last_nx = gnt;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      last     <= 1'b0;
      cnt      <= '0;
      rom_addr <= '0;
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      a_dout   <= '0;
      b_dout   <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
      last  <= last_nx;
      cnt   <= start ? '0 : rom_cs ? cnt + TOUT_W'(1) : cnt;
      if (start) rom_addr <= gnt_nx ? b_addr : a_addr;
      a_ack <= (fin & ~gnt) | a_hit;
      b_ack <= (fin &  gnt) | b_hit;
      if (fin & ~gnt) a_dout <= done_ok ? rom_data : 8'h00;
      if (fin &  gnt) b_dout <= done_ok ? rom_data : 8'h00;
      err <= tout | (err & ~clr_err);
    end
  end
endmodule

// File: tb/tb_jt10_adpcm_romarb.sv
// Bench for jt10_adpcm_romarb: directed latency/arbitration/timeout/reset/cache steps, then a
// randomized phase scored against a per-requester pending-fetch model and an address-hashed ROM.
module tb_jt10_adpcm_romarb;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        a_req = 1'b0, b_req = 1'b0, a_ack, b_ack;
  logic [23:0] a_addr = '0, b_addr = '0, rom_addr;
  logic [7:0]  a_dout, b_dout, rom_data = '0;
  logic        rom_cs, rom_ok = 1'b0, flush = 1'b0, clr_err = 1'b0, err;

  int n_assert = 0, n_fail = 0;
  int ok_mode = 0, fixed_lat = 1, lat = 1, age = 0;
  bit cs_was = 1'b0;
  int l, c, first, second, n_ev;

  always #5 clk = ~clk;

  jt10_adpcm_romarb #(.TOUT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_dout(a_dout),
    .b_req(b_req), .b_addr(b_addr), .b_ack(b_ack), .b_dout(b_dout),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_ok(rom_ok), .rom_data(rom_data),
    .flush(flush), .clr_err(clr_err), .err(err)
  );

  function automatic logic [7:0] romf(input logic [23:0] ad);
    return ad[7:0] ^ ad[15:8] ^ ad[23:16] ^ 8'hC2;
  endfunction

  // ROM model: mode 0 answers lat cycles after cs rises, 1 holds ok high (stale byte in the
  // first cs cycle), 2 never answers
  always @(posedge clk) begin
    #1;
    if (rom_cs) begin
      age = cs_was ? age + 1 : 0;
      if (!cs_was) lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
    end
    cs_was = rom_cs;
    case (ok_mode)
      1: begin rom_ok = 1'b1; rom_data = (rom_cs && age == 0) ? 8'hEE : romf(rom_addr); end
      2: begin rom_ok = 1'b0; rom_data = 8'($urandom); end
      default: begin
        rom_ok   = rom_cs && age >= lat;
        rom_data = rom_ok ? romf(rom_addr) : 8'($urandom);
      end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; a_req = 1'b0; b_req = 1'b0; flush = 1'b0; clr_err = 1'b0;
    a_addr = '0; b_addr = '0; ok_mode = 0; fixed_lat = 1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // returns cycles from request to ack (-1 if none within lim) and cycles with rom_cs high
  task automatic wait_ack(input bit is_b, input int lim, output int lat_o, output int cs_o);
    lat_o = -1; cs_o = 0;
    for (int i = 1; i <= lim; i++) begin
      tick();
      if (rom_cs) cs_o++;
      if ((is_b ? b_ack : a_ack) === 1'b1) begin lat_o = i; break; end
    end
  endtask

  task automatic serve_pair(output int f, output int s);
    f = -1; s = -1;
    for (int i = 0; i < 20 && s < 0; i++) begin
      tick();
      if (b_ack) begin if (f < 0) f = 1; else s = 1; b_req = 1'b0; end
      if (a_ack) begin if (f < 0) f = 0; else s = 0; a_req = 1'b0; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("rst_cs", rom_cs, 0);       chk("rst_addr", rom_addr, 0);
    chk("rst_a_ack", a_ack, 0);     chk("rst_b_ack", b_ack, 0);
    chk("rst_a_dout", a_dout, 0);   chk("rst_b_dout", b_dout, 0);
    chk("rst_err", err, 0);

    // single A fetch at minimum latency; req held through its ack cycle
    a_addr = 24'h012345; a_req = 1'b1;
    tick(); chk("t1_cs", rom_cs, 1); chk("t1_addr", rom_addr, 24'h012345); chk("t1_ack_c1", a_ack, 0);
    tick(); chk("t1_ack_c2", a_ack, 0); chk("t1_cs_c2", rom_cs, 1);
    tick(); chk("t1_ack_c3", a_ack, 1); chk("t1_dout", a_dout, 8'hA5); chk("t1_cs_drop", rom_cs, 0);
    tick(); chk("t1_no_regrant", rom_cs, 0); chk("t1_ack_pulse", a_ack, 0);
    a_req = 1'b0;
    tick(); chk("t1_addr_hold", rom_addr, 24'h012345);

    // timeout: ROM never answers
    ok_mode = 2; a_addr = 24'h0ABCDE; a_req = 1'b1;
    wait_ack(1'b0, 300, l, c);
    chk("tout_lat", l, 257); chk("tout_dout", a_dout, 8'h00); chk("tout_err", err, 1);
    a_req = 1'b0;
    tick(); tick(); chk("err_sticky", err, 1);
    clr_err = 1'b1; tick(); clr_err = 1'b0; chk("err_clr", err, 0);
    a_addr = 24'h0ABCDF; a_req = 1'b1;
    repeat (256) tick();
    chk("tout2_pre_err", err, 0);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("tout2_ack", a_ack, 1); chk("tout2_err_wins", err, 1);
    a_req = 1'b0;

    // rom_ok stuck high: the stale first-cycle byte must not be taken
    do_reset();
    ok_mode = 1; b_addr = 24'h000010; b_req = 1'b1;
    wait_ack(1'b1, 10, l, c);
    chk("perm_lat", l, 3); chk("perm_dout", b_dout, romf(24'h000010));
    b_req = 1'b0;

    // round robin: B favoured after reset; a lone B fetch in between leaves B as last served
    do_reset();
    a_addr = 24'h000AAA; b_addr = 24'h000BBB; a_req = 1'b1; b_req = 1'b1;
    serve_pair(first, second);
    chk("rr1_first", first, 1); chk("rr1_second", second, 0);
    chk("rr1_a_dout", a_dout, romf(24'h000AAA)); chk("rr1_b_dout", b_dout, romf(24'h000BBB));
    tick();
    b_addr = 24'h000BBC; b_req = 1'b1;
    wait_ack(1'b1, 10, l, c); chk("rr_lone_b", l, 3); b_req = 1'b0;
    tick();
    a_addr = 24'h000AAB; b_addr = 24'h000BBD; a_req = 1'b1; b_req = 1'b1;
    serve_pair(first, second);
    chk("rr2_first", first, 0); chk("rr2_second", second, 1);

    // reset during BUSY abandons the fetch; first grant only at an edge after release
    do_reset();
    fixed_lat = 4; a_addr = 24'h00F00D; a_req = 1'b1;
    tick(); tick(); chk("rstb_cs", rom_cs, 1);
    #2 rst_n = 1'b0;
    #1 chk("rstb_async_cs", rom_cs, 0); chk("rstb_async_addr", rom_addr, 0);
    a_req = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;
    n_ev = 0;
    repeat (8) begin tick(); if (a_ack || b_ack || rom_cs) n_ev++; end
    chk("rstb_abandon", n_ev, 0);
    rst_n = 1'b0; a_req = 1'b1; fixed_lat = 1;
    @(posedge clk); #3 rst_n = 1'b1;
    #1 chk("rel_no_grant", rom_cs, 0);
    @(posedge clk); #1 chk("rel_grant", rom_cs, 1);
    wait_ack(1'b0, 10, l, c);
    chk("rel_dout", a_dout, romf(24'h00F00D));
    a_req = 1'b0; tick();

    // repeated B address: cache hit when enabled, ROM otherwise; flush forces ROM
    do_reset();
    b_addr = 24'h000100; b_req = 1'b1;
    wait_ack(1'b1, 10, l, c); chk("c1_lat", l, 3); chk("c1_cs", c, 2);
    b_req = 1'b0; tick();
    b_req = 1'b1;
    wait_ack(1'b1, 10, l, c);
`ifdef JT10_ROMARB_CACHE_EN
    chk("c2_lat", l, 1); chk("c2_cs", c, 0);
`else
    chk("c2_lat", l, 3); chk("c2_cs", c, 2);
`endif
    chk("c2_dout", b_dout, romf(24'h000100));
    b_req = 1'b0; tick();
    flush = 1'b1; tick(); flush = 1'b0;
    b_req = 1'b1;
    wait_ack(1'b1, 10, l, c); chk("c3_lat", l, 3); chk("c3_cs", c, 2);
    b_req = 1'b0; tick();

    // randomized traffic with random ROM latency against a pending-fetch scoreboard
    do_reset();
    fixed_lat = 0;
    begin
      bit pa = 0, pb = 0;
      logic [23:0] aa = '0, ba = '0;
      int sa = 0, sb = 0, acks = 0;
      for (int k = 0; k < 400; k++) begin
        tick();
        if (rom_cs) chk("rnd_rom_addr", (pa && rom_addr == aa) || (pb && rom_addr == ba), 1);
        if (a_ack) begin
          chk("rnd_a_pend", pa, 1); chk("rnd_a_dout", a_dout, romf(aa));
          chk("rnd_a_minlat", (k - sa) >= 3, 1);
          pa = 0; a_req = 1'b0; acks++;
        end
        if (b_ack) begin
          chk("rnd_b_pend", pb, 1); chk("rnd_b_dout", b_dout, romf(ba));
          chk("rnd_b_minlat", (k - sb) >= 3, 1);
          pb = 0; b_req = 1'b0; acks++;
        end
        if (pa) chk("rnd_a_wait", (k - sa) <= 24, 1);
        if (pb) chk("rnd_b_wait", (k - sb) <= 24, 1);
        if (k < 370 && !pa && !a_ack && $urandom_range(0, 2) == 0) begin
          logic [23:0] n = 24'($urandom);
          aa = (n == aa) ? n ^ 24'h1 : n; a_addr = aa; a_req = 1'b1; pa = 1; sa = k;
        end
        if (k < 370 && !pb && !b_ack && $urandom_range(0, 2) == 0) begin
          logic [23:0] n = 24'($urandom);
          ba = (n == ba) ? n ^ 24'h1 : n; b_addr = ba; b_req = 1'b1; pb = 1; sb = k;
        end
      end
      chk("rnd_drained", pa | pb, 0);
      chk("rnd_traffic", acks > 40, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
